spi_bus_arbiter: RTL and testbench
==================================

# spi_bus_arbiter

Shares one `spi_master` instance among `NUM_REQ` requesters. Each requester runs a multi-word SPI transaction under its own chip-select. The block arbitrates round-robin and drives chip-select setup, hold and gap timing. It sequences one `spi_master` start per word and routes transmit and receive words to and from the granted requester. It sits between the peripheral drivers and the single `spi_master` on the board SPI bus.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `DATA_WIDTH`, default 8: word width; must match `spi_master`.
- `LEN_WIDTH`, default 8: width of each length field.
- `CS_DELAY`, default 4: clock cycles for CS setup, CS hold and CS-high gap; must be ≥1.

- `i_clk`  in  1: clock.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_req`  in  NUM_REQ: transaction request, level; held until `o_done[g]`.
- `i_len`  in  NUM_REQ*LEN_WIDTH: per-requester word count minus 1.
- `i_tx_data`  in  NUM_REQ*DATA_WIDTH: per-requester next transmit word.
- `o_gnt`  out  NUM_REQ: one-hot grant, held for the whole transaction.
- `o_tx_ready`  out  NUM_REQ: 1-cycle pulse; the current `i_tx_data` word was consumed.
- `o_rx_data`  out  DATA_WIDTH: last received word, shared by all requesters.
- `o_rx_valid`  out  NUM_REQ: 1-cycle pulse; `o_rx_data` is valid for requester g.
- `o_done`  out  NUM_REQ: 1-cycle pulse when the transaction ends.
- `o_cs_n`  out  NUM_REQ: active-low chip-selects.
- `o_spi_start`  out  1: to `spi_master` `i_start`.
- `o_spi_din`  out  DATA_WIDTH: to `spi_master` `i_din`.
- `i_spi_dout`  in  DATA_WIDTH: from `spi_master` `o_dout`.
- `i_spi_done`  in  1: from `spi_master` `o_done`.

## Operation
- States: IDLE, SETUP, START, WAIT, HOLD, GAP.
- IDLE:
  - If any `i_req` is set, pick winner g round-robin, searching from `last+1` upward with wrap.
  - Latch g and `i_len[g]`, clear the word counter, go to SETUP.
  - Next cycle, `o_gnt[g]` is 1 and `o_cs_n[g]` is 0.
- SETUP: lasts CS_DELAY cycles with CS low, then START.
- START: lasts 1 cycle.
  - `o_spi_start`=1, `o_spi_din`=`i_tx_data[g]`, `o_tx_ready[g]`=1.
  - Then WAIT.
- WAIT: wait for `i_spi_done`.
  - On `i_spi_done`, register `i_spi_dout` into `o_rx_data`; `o_rx_valid[g]` pulses the next cycle.
  - If word counter == latched len, go to HOLD; else increment counter and go to START.
- HOLD: CS_DELAY cycles with CS still low, then GAP.
  - `o_cs_n[g]` rises and `o_gnt` clears on HOLD exit.
  - `o_done[g]` pulses on the first GAP cycle.
- GAP: CS_DELAY cycles with all CS high.
  - Set `last`=g, then go to IDLE.
- Word counter is LEN_WIDTH bits. Len is compared by equality, so len = 2^LEN_WIDTH−1 transfers 2^LEN_WIDTH words with no wrap.
- `i_len` and `i_req` changes after grant are ignored; a transaction always runs len+1 words.
- Reset (asynchronous):
  - State to IDLE, `o_cs_n` all 1, `o_gnt` 0.
  - All pulse outputs 0, `o_rx_data` 0.
  - `last`=NUM_REQ−1, so requester 0 wins first.
  - Applies mid-transaction too. `spi_master` shares the system reset.

## Timing
- `i_req` seen in IDLE at cycle N: gnt and CS asserted at N+1.
- First `o_spi_start` at N+1+CS_DELAY.
- `o_spi_start` in the cycle after `i_spi_done` is legal, since `spi_master` is back in IDLE.
- Consecutive words are separated by exactly 1 cycle (the START cycle) after each `i_spi_done`.
- `o_rx_valid` comes 1 cycle after `i_spi_done`.
- Each requester must present word k+1 on `i_tx_data` by the cycle after the k-th `o_tx_ready` pulse.
- Minimum CS-high time between transactions: CS_DELAY+1 cycles (GAP plus IDLE).
- `o_spi_start`, `o_tx_ready` and `o_spi_din` are decoded from registered state. All other outputs are registered.

## Structure
- Package `spi_ctrl_pkg`: state enum `spi_arb_state_t`. Port widths and CS_DELAY come from the module parameters, not the package.
- Sub-module `rr_arbiter`, parameter N: inputs `req[N]` and `last` index; outputs one-hot `gnt` and index. Purely combinational, registered by the parent.

## Test plan
- Single word: req0, len=0, tx 0xA5, slave model returns 0x3C.
  - `cs_n[0]` low 4 cycles before one start, mosi shows 0xA5.
  - `o_rx_valid[0]` with 0x3C.
  - `o_done[0]` on the first GAP cycle; `cs_n[0]` high from that cycle.
- Burst: req1, len=2, words 0x11, 0x22, 0x33.
  - Exactly 3 starts and 3 `tx_ready[1]` pulses; mosi order 0x11, 0x22, 0x33.
  - `cs_n[1]` continuously low; 1-cycle spacing between done and next start.
- Fairness: req0 and req1 both held from reset.
  - Grants alternate 0, 1, 0, 1; never two CS low at once.
  - CS-high gap ≥5 cycles between transactions.
- Request drop: req1 deasserted and `i_len[1]` changed mid-burst of len=3 → all 4 words complete with the original len.
- Reset mid-word: `i_rst_n` low during WAIT.
  - Same-cycle `cs_n`=all 1, `gnt`=0, `spi_start`=0.
  - After release with req0 and req1 both set, req0 is granted first.
- Max length: len=255 → exactly 256 starts, then one `o_done`.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types for the SPI bus arbiter: the transaction sequencer state encoding.
package spi_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_START,
      ST_WAIT,
      ST_HOLD,
      ST_GAP
   } spi_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from last+1 with wrap and
// returns the winner both one-hot and as an index. The parent registers it.
module rr_arbiter #(
   parameter int N = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] cand;
   logic          found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         cand = IW'((int'(last) + i) % N);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one spi_master among NUM_REQ requesters: round-robin grant, CS
// setup/hold/gap timing, one spi_master start per word, and rx/tx routing.
module spi_bus_arbiter
   import spi_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8,
   parameter int CS_DELAY   = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [NUM_REQ-1:0]              i_req,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]    i_len,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_tx_data,
   output logic [NUM_REQ-1:0]              o_gnt,
   output logic [NUM_REQ-1:0]              o_tx_ready,
   output logic [DATA_WIDTH-1:0]           o_rx_data,
   output logic [NUM_REQ-1:0]              o_rx_valid,
   output logic [NUM_REQ-1:0]              o_done,
   output logic [NUM_REQ-1:0]              o_cs_n,
   output logic                            o_spi_start,
   output logic [DATA_WIDTH-1:0]           o_spi_din,
   input  logic [DATA_WIDTH-1:0]           i_spi_dout,
   input  logic                            i_spi_done
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int DW = (CS_DELAY > 1) ? $clog2(CS_DELAY) : 1;

   spi_arb_state_t        state;
   logic [IW-1:0]         last;
   logic [IW-1:0]         g_idx;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  cnt;
   logic [DW-1:0]         dly;
   logic                  dly_done;

   logic [NUM_REQ-1:0]    win_gnt;
   logic [IW-1:0]         win_idx;
   logic                  win_any;

   logic [LEN_WIDTH-1:0]  len_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0] tx_arr  [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign len_arr[i] = i_len[i*LEN_WIDTH +: LEN_WIDTH];
      assign tx_arr[i]  = i_tx_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req  (i_req),
      .last (last),
      .gnt  (win_gnt),
      .idx  (win_idx),
      .any  (win_any)
   );

   // One counter serves SETUP, HOLD and GAP; it is cleared on every entry.
   assign dly_done = (dly == DW'(CS_DELAY - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         last       <= IW'(NUM_REQ - 1);
         g_idx      <= '0;
         len_q      <= '0;
         cnt        <= '0;
         dly        <= '0;
         o_gnt      <= '0;
         o_cs_n     <= '1;
         o_rx_data  <= '0;
         o_rx_valid <= '0;
         o_done     <= '0;
      end else begin
         o_rx_valid <= '0;
         o_done     <= '0;
         case (state)
            ST_IDLE: begin
               if (win_any) begin
                  g_idx  <= win_idx;
                  len_q  <= len_arr[win_idx];
                  cnt    <= '0;
                  dly    <= '0;
                  o_gnt  <= win_gnt;
                  o_cs_n <= ~win_gnt;
                  state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (dly_done) begin
                  dly   <= '0;
                  state <= ST_START;
               end else begin
                  dly <= dly + 1'b1;
               end
            end
            ST_START: state <= ST_WAIT;
            ST_WAIT: begin
               if (i_spi_done) begin
                  o_rx_data  <= i_spi_dout;
                  o_rx_valid <= o_gnt;
                  // Equality compare lets len = all-ones run the full 2^LEN_WIDTH words.
                  if (cnt == len_q) begin
                     dly   <= '0;
                     state <= ST_HOLD;
                  end else begin
                     cnt   <= cnt + 1'b1;
                     state <= ST_START;
                  end
               end
            end
            ST_HOLD: begin
               if (dly_done) begin
                  dly    <= '0;
                  o_cs_n <= '1;
                  o_gnt  <= '0;
                  o_done <= o_gnt;
                  state  <= ST_GAP;
               end else begin
                  dly <= dly + 1'b1;
               end
            end
            ST_GAP: begin
               if (dly_done) begin
                  dly   <= '0;
                  last  <= g_idx;
                  state <= ST_IDLE;
               end else begin
                  dly <= dly + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_spi_start = (state == ST_START);
   assign o_tx_ready  = o_spi_start ? o_gnt : '0;
   assign o_spi_din   = tx_arr[g_idx];

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed scenarios plus random rounds, with a
// responding spi_master/slave model and a transaction-level reference model.
module tb_spi_bus_arbiter;

   localparam int N   = 3;
   localparam int DW  = 8;
   localparam int LW  = 8;
   localparam int CSD = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*LW-1:0] len;
   logic [N*DW-1:0] tx;
   logic [N-1:0]    gnt, tx_ready, rx_valid, done, cs_n;
   logic [DW-1:0]   rx_data, spi_din, spi_dout;
   logic            spi_start, spi_done;

   always #5 clk = ~clk;

   spi_bus_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .CS_DELAY(CSD)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_len(len), .i_tx_data(tx),
      .o_gnt(gnt), .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
      .o_done(done), .o_cs_n(cs_n), .o_spi_start(spi_start), .o_spi_din(spi_din),
      .i_spi_dout(spi_dout), .i_spi_done(spi_done)
   );

   int n_cmp = 0, n_fail = 0, cyc = 0;
   logic [7:0]    words [N][256];
   int            ptr [N];
   logic [LW-1:0] len_in [N];
   int            mdl_len [N];
   int            mdl_last;
   int            exp_order [$];
   int            done_cnt = 0;
   bit            auto_drop;
   bit            in_txn;
   int            mon_g, mon_nready, cs_low_cyc, cs_high_cyc, last_sdone_cyc;
   logic [7:0]    mon_mosi [$];
   int            cd, lat_lo, lat_hi, prev_rdy, rxp_g;
   bit            fixed_en, rxp;
   logic [7:0]    fixed_resp, pend_resp, rxp_data;
   logic [N-1:0]  ones;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int g);
      logic [N-1:0] r;
      r = '0;
      r[g] = 1'b1;
      return r;
   endfunction

   function automatic logic [7:0] resp(input logic [7:0] mosi);
      return fixed_en ? fixed_resp : ({mosi[3:0], mosi[7:4]} ^ 8'hC3);
   endfunction

   // Round-robin rule: first requester found scanning upward from last+1.
   function automatic int next_winner(input logic [N-1:0] mask, input int l);
      for (int i = 1; i <= N; i++) begin
         if (mask[(l + i) % N]) return (l + i) % N;
      end
      return 0;
   endfunction

   task automatic plan(input logic [N-1:0] mask, input int n, input bit drop);
      logic [N-1:0] m;
      int l, w;
      m = mask;
      l = mdl_last;
      for (int i = 0; i < n; i++) begin
         w = next_winner(m, l);
         exp_order.push_back(w);
         l = w;
         if (drop) m[w] = 1'b0;
      end
   endtask

   task automatic drive_tx();
      for (int g = 0; g < N; g++) begin
         tx[g*DW +: DW]  = words[g][ptr[g] & 255];
         len[g*LW +: LW] = len_in[g];
      end
   endtask

   task automatic verify_txn();
      int eg;
      if (exp_order.size() == 0) chk("unexpected_txn", 1, 0);
      else begin
         eg = exp_order.pop_front();
         chk("grant_order", mon_g, eg);
      end
      chk("word_count", mon_mosi.size(), mdl_len[mon_g] + 1);
      chk("tx_ready_count", mon_nready, mdl_len[mon_g] + 1);
      for (int k = 0; k < mon_mosi.size() && k <= mdl_len[mon_g]; k++)
         chk("mosi_word", mon_mosi[k], words[mon_g][k]);
      mdl_last = mon_g;
      ptr[mon_g] = 0;
      done_cnt++;
      if (auto_drop) req[mon_g] = 1'b0;
   endtask

   task automatic tick();
      logic [N-1:0] exp_v;
      @(posedge clk);
      #1;
      cyc++;
      if (prev_rdy >= 0) begin
         ptr[prev_rdy]++;
         prev_rdy = -1;
      end
      if (rxp) begin
         chk("rx_valid", rx_valid, oh(rxp_g));
         chk("rx_data", rx_data, rxp_data);
         rxp = 1'b0;
      end else begin
         chk("rx_valid_idle", rx_valid, 0);
      end
      spi_done = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            spi_done = 1'b1;
            spi_dout = pend_resp;
            last_sdone_cyc = cyc;
            rxp = 1'b1;
            rxp_g = mon_g;
            rxp_data = pend_resp;
         end
      end
      exp_v = ~cs_n;
      chk("gnt_matches_cs", gnt, exp_v);
      if (done != '0) begin
         if (!in_txn) chk("done_outside_txn", 0, 1);
         chk("done_onehot", done, oh(mon_g));
         chk("done_cs_high", cs_n, ones);
         chk("done_gnt_clear", gnt, 0);
         chk("done_timing", cyc - last_sdone_cyc, CSD + 1);
         in_txn = 1'b0;
         cs_high_cyc = cyc;
         verify_txn();
      end
      if (!in_txn && cs_n != ones) begin
         in_txn = 1'b1;
         mon_g = 0;
         for (int g = 0; g < N; g++) if (!cs_n[g]) mon_g = g;
         mon_mosi.delete();
         mon_nready = 0;
         cs_low_cyc = cyc;
         if (cs_high_cyc >= 0) chk("cs_gap", (cyc - cs_high_cyc) >= CSD + 1, 1);
      end
      if (in_txn) begin
         exp_v = ~oh(mon_g);
         chk("cs_hold", cs_n, exp_v);
      end
      if (spi_start) begin
         if (!in_txn) chk("start_outside_txn", 0, 1);
         chk("tx_ready_start", tx_ready, oh(mon_g));
         if (mon_mosi.size() == 0) chk("setup_time", cyc - cs_low_cyc, CSD);
         else chk("word_spacing", cyc - last_sdone_cyc, 1);
         mon_mosi.push_back(spi_din);
         if (tx_ready[mon_g]) mon_nready++;
         cd = $urandom_range(lat_hi, lat_lo);
         pend_resp = resp(spi_din);
         prev_rdy = mon_g;
      end else begin
         chk("tx_ready_idle", tx_ready, 0);
      end
      drive_tx();
   endtask

   task automatic wait_done(input int target, input int budget);
      int b;
      b = 0;
      while (done_cnt < target && b < budget) begin
         tick();
         b++;
      end
      if (done_cnt < target) chk("timeout_done", done_cnt, target);
   endtask

   task automatic clear_tb();
      req = '0;
      spi_done = 1'b0;
      in_txn = 1'b0;
      rxp = 1'b0;
      cd = 0;
      prev_rdy = -1;
      cs_high_cyc = -1;
      last_sdone_cyc = 0;
      exp_order.delete();
      for (int g = 0; g < N; g++) ptr[g] = 0;
      mdl_last = N - 1;
      drive_tx();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      clear_tb();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cs_n", cs_n, ones);
      chk("rst_gnt", gnt, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_spi_start", spi_start, 0);
      chk("rst_tx_ready", tx_ready, 0);
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic [N-1:0] mask);
      for (int g = 0; g < N; g++) if (mask[g]) len_in[g] = LW'(mdl_len[g]);
      plan(mask, $countones(mask), 1'b1);
      req = req | mask;
      drive_tx();
   endtask

   task automatic rand_words(input int g, input int n);
      for (int k = 0; k < n; k++) words[g][k] = 8'($urandom);
   endtask

   initial begin
      int b;
      logic [N-1:0] m;
      ones = '1;
      spi_dout = '0;
      fixed_en = 1'b0;
      fixed_resp = '0;
      auto_drop = 1'b1;
      lat_lo = 1;
      lat_hi = 3;
      for (int g = 0; g < N; g++) begin
         len_in[g] = '0;
         mdl_len[g] = 0;
         rand_words(g, 256);
      end
      rst_n = 1'b0;
      apply_reset();

      // single word with a fixed slave reply
      mdl_len[0] = 0;
      words[0][0] = 8'hA5;
      fixed_en = 1'b1;
      fixed_resp = 8'h3C;
      issue(3'b001);
      wait_done(done_cnt + 1, 200);
      chk("single_rx_data", rx_data, 8'h3C);
      fixed_en = 1'b0;

      // three-word burst on requester 1
      mdl_len[1] = 2;
      words[1][0] = 8'h11;
      words[1][1] = 8'h22;
      words[1][2] = 8'h33;
      issue(3'b010);
      wait_done(done_cnt + 1, 300);

      // fairness: two requesters held from reset
      apply_reset();
      auto_drop = 1'b0;
      mdl_len[0] = $urandom_range(2, 0);
      mdl_len[1] = $urandom_range(2, 0);
      len_in[0] = LW'(mdl_len[0]);
      len_in[1] = LW'(mdl_len[1]);
      plan(3'b011, 4, 1'b0);
      req = 3'b011;
      drive_tx();
      wait_done(done_cnt + 4, 800);
      req = '0;
      auto_drop = 1'b1;
      chk("fairness_all_seen", exp_order.size(), 0);

      // request and length dropped mid-burst
      mdl_len[1] = 3;
      rand_words(1, 4);
      issue(3'b010);
      b = 0;
      while (!(in_txn && mon_g == 1 && mon_nready >= 2) && b < 200) begin
         tick();
         b++;
      end
      if (b >= 200) chk("timeout_drop", 0, 1);
      req[1] = 1'b0;
      len_in[1] = '0;
      drive_tx();
      wait_done(done_cnt + 1, 300);

      // requester 0 completes so that last points at 0
      mdl_len[0] = 1;
      rand_words(0, 2);
      issue(3'b001);
      wait_done(done_cnt + 1, 200);

      // reset while requester 1 waits on a word
      lat_lo = 4;
      lat_hi = 4;
      mdl_len[1] = 3;
      issue(3'b010);
      b = 0;
      while (!(in_txn && mon_mosi.size() == 1) && b < 100) begin
         tick();
         b++;
      end
      if (b >= 100) chk("timeout_reset_wait", 0, 1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_cs_n", cs_n, ones);
      chk("midrst_gnt", gnt, 0);
      chk("midrst_spi_start", spi_start, 0);
      clear_tb();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      lat_lo = 1;
      lat_hi = 3;
      mdl_len[0] = 0;
      mdl_len[1] = 1;
      issue(3'b011);
      wait_done(done_cnt + 2, 400);

      // maximum length burst
      lat_lo = 1;
      lat_hi = 1;
      mdl_len[0] = 255;
      rand_words(0, 256);
      issue(3'b001);
      wait_done(done_cnt + 1, 3000);
      lat_hi = 4;

      // random rounds
      for (int r = 0; r < 8; r++) begin
         m = N'($urandom_range(7, 1));
         for (int g = 0; g < N; g++) begin
            mdl_len[g] = $urandom_range(4, 0);
            rand_words(g, 5);
         end
         issue(m);
         wait_done(done_cnt + $countones(m), 1500);
      end

      chk("no_pending_txn", exp_order.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
